instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - RESET_PC, 32'h0000_0000, PC value loaded on reset.
  - NOP_WORD, 32'h0000_0000, word placed in IF/ID on reset and squash.
REQ-002 Ports (name, direction, width, meaning), one per line:
  - clk, in, 1, single clock; all state updates on rising edge.
  - reset, in, 1, synchronous, active-high.
  - stall, in, 1, hold PC and IF/ID contents this cycle.
  - branch_taken, in, 1, taken branch resolved in ID for the IF/ID instruction.
  - branch_offset, in, 16, signed word offset of that branch.
  - jump, in, 1, J-type redirect for the IF/ID instruction.
  - jump_index, in, 26, J-type target field.
  - PC_address, out, 32, byte address driven to instruction memory.
  - instruction, in, 32, word returned combinationally by instruction memory for PC_address.
  - if_id_instruction, out, 32, registered fetched word.
  - if_id_pc_plus4, out, 32, registered PC+4 of that word.
  - if_id_valid, out, 1, IF/ID holds a real instruction.
  - fetch_count, out, 32, number of instructions delivered valid into IF/ID.
REQ-003 One clock domain; reset is synchronous and active-high.

Function
REQ-004 PC_address SHALL equal the internal PC register, with no combinational path from any input.
REQ-005 Next-PC priority SHALL be: reset > stall > redirect > sequential.
REQ-006 Redirect SHALL be honoured only when stall=0 and if_id_valid=1; otherwise branch_taken and jump are ignored.
REQ-007 If jump=1 and branch_taken=1 together, jump SHALL win.
REQ-008 Branch target SHALL be if_id_pc_plus4 + (sign-extended branch_offset << 2), computed modulo 2^32.
REQ-009 Jump target SHALL be {if_id_pc_plus4[31:28], jump_index, 2'b00}.
REQ-010 On a sequential cycle (no stall, no honoured redirect):
  - PC <= PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - IF/ID <= {instruction, PC+4}, if_id_valid <= 1.
  - fetch_count increments by 1.
REQ-011 On an honoured redirect:
  - PC <= target.
  - if_id_instruction <= NOP_WORD, if_id_pc_plus4 <= 0, if_id_valid <= 0 (the word fetched this cycle is squashed).
  - fetch_count is unchanged.
REQ-012 While stall=1, PC, all IF/ID outputs and fetch_count SHALL hold their values.
REQ-013 PC_address[1:0] SHALL always be 2'b00; targets are word-aligned by construction.
REQ-014 Fetch-to-IF/ID latency SHALL be 1 cycle; redirect penalty SHALL be exactly 1 bubble cycle.
REQ-015 fetch_count SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-016 While reset=1 at a clock edge:
  - PC <= RESET_PC.
  - if_id_instruction <= NOP_WORD, if_id_pc_plus4 <= 0, if_id_valid <= 0, fetch_count <= 0.
REQ-017 Reset SHALL override stall and redirect in the same cycle, including a reset asserted in the middle of a stall or redirect.
REQ-018 The first fetch after reset deassertion SHALL be from RESET_PC.

Verification
REQ-019 Memory image: 0x02114020 @0, sub @4, lw @8, sw @12, 0x11090003 (beq) @16, add @32.
  - Release reset with no stall -> PC_address sequence 0, 4, 8.
  - First valid IF/ID: 0x02114020 with if_id_pc_plus4=4.
REQ-020 Branch:
  - Stimulus: when if_id_instruction=0x11090003 (pc_plus4=20), drive branch_taken=1, branch_offset=3.
  - Response: next PC_address=32; following cycle if_id_valid=0; then add @32 is valid with pc_plus4=36.
REQ-021 Stall:
  - Stimulus: assert stall 3 cycles at PC=8.
  - Response: PC_address stays 8; IF/ID and fetch_count frozen; fetch resumes at 8 after stall drops.
REQ-022 Stall plus branch:
  - Stimulus: stall=1 together with branch_taken=1.
  - Response: no redirect; branch honoured in the first cycle stall=0.
REQ-023 Jump over branch and wrap:
  - Stimulus: jump=1 (jump_index=0x0000002) together with branch_taken=1, if_id_pc_plus4=0x00000014.
  - Response: PC=0x00000008.
  - Stimulus: RESET_PC=0xFFFFFFFC.
  - Response: second fetch address is 0x00000000.
REQ-024 Reset mid-redirect:
  - Stimulus: reset=1 in the same cycle as a jump.
  - Response: PC=RESET_PC, if_id_valid=0, fetch_count=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Handles stall, branch/jump redirect with a one-bubble squash, and a count of delivered instructions.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] PC_address,
  input  logic [31:0] instruction,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instruction_q, if_id_instruction_d;
  logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        redirect;

  // A redirect only makes sense for a real instruction sitting in IF/ID; jump outranks branch.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    branch_target = if_id_pc_plus4_q + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    jump_target   = {if_id_pc_plus4_q[31:28], jump_index, 2'b00};
    redirect      = !stall && if_id_valid_q && (jump || branch_taken);

    pc_d                = pc_q;
    if_id_instruction_d = if_id_instruction_q;
    if_id_pc_plus4_d    = if_id_pc_plus4_q;
    if_id_valid_d       = if_id_valid_q;
    fetch_count_d       = fetch_count_q;

    if (stall) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d                = jump ? jump_target : branch_target;
      if_id_instruction_d = NOP_WORD;
      if_id_pc_plus4_d    = 32'd0;
      if_id_valid_d       = 1'b0;
    end else begin
      pc_d                = pc_plus4;
      if_id_instruction_d = instruction;
      if_id_pc_plus4_d    = pc_plus4;
      if_id_valid_d       = 1'b1;
      fetch_count_d       = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q                <= RESET_PC;
      if_id_instruction_q <= NOP_WORD;
      if_id_pc_plus4_q    <= 32'd0;
      if_id_valid_q       <= 1'b0;
      fetch_count_q       <= 32'd0;
    end else begin
      pc_q                <= pc_d;
      if_id_instruction_q <= if_id_instruction_d;
      if_id_pc_plus4_q    <= if_id_pc_plus4_d;
      if_id_valid_q       <= if_id_valid_d;
      fetch_count_q       <= fetch_count_d;
    end
  end

  assign PC_address        = pc_q;
  assign if_id_instruction = if_id_instruction_q;
  assign if_id_pc_plus4    = if_id_pc_plus4_q;
  assign if_id_valid       = if_id_valid_q;
  assign fetch_count       = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected IF/ID words are queued with each stimulus
// and popped by a monitor whenever a newly loaded valid word appears.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] PC_address, instruction, if_id_instruction, if_id_pc_plus4, fetch_count;
  logic        if_id_valid;

  logic        reset_w;
  logic [31:0] pc_w, instruction_w, if_id_instruction_w, if_id_pc_plus4_w, fetch_count_w;
  logic        if_id_valid_w;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic        new_word = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h02114020;
      32'd4:   return 32'h02324822;
      32'd8:   return 32'h8D280004;
      32'd12:  return 32'hAD280008;
      32'd16:  return 32'h11090003;
      32'd32:  return 32'h01095020;
      default: return {16'hF00D, a[15:0]};
    endcase
  endfunction

  assign instruction   = imem(PC_address);
  assign instruction_w = imem(pc_w);

  instruction_fetch #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .PC_address(PC_address), .instruction(instruction),
    .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_WORD(32'h0000_0000)) dut_wrap (
    .clk(clk), .reset(reset_w), .stall(1'b0), .branch_taken(1'b0),
    .branch_offset(16'h0000), .jump(1'b0), .jump_index(26'h0),
    .PC_address(pc_w), .instruction(instruction_w),
    .if_id_instruction(if_id_instruction_w), .if_id_pc_plus4(if_id_pc_plus4_w),
    .if_id_valid(if_id_valid_w), .fetch_count(fetch_count_w)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic expectWord(input logic [31:0] instr, input logic [31:0] pc4);
    exp_q.push_back({instr, pc4});
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic br,
                               input logic [15:0] off, input logic jmp, input logic [25:0] idx);
    reset = rst; stall = st; branch_taken = br; branch_offset = off; jump = jmp; jump_index = idx;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkState(input string name, input logic [31:0] pc, input logic valid, input logic [31:0] cnt);
    checkOutput({name, "_pc"}, PC_address, pc);
    checkOutput({name, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    checkOutput({name, "_count"}, fetch_count, cnt);
  endtask

  always @(posedge clk) new_word <= !reset && !stall;

  // A fresh valid word in IF/ID must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (new_word && if_id_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word actual=%h expected=none", if_id_instruction);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        checkOutput("ifid_instr", if_id_instruction, e[63:32]);
        checkOutput("ifid_pc4", if_id_pc_plus4, e[31:0]);
      end
    end
  end

  initial begin
    reset_w = 1'b1;
    applyStimulus(1, 0, 0, 16'h0, 0, 26'h0);
    checkState("reset", 32'd0, 1'b0, 32'd0);
    checkOutput("reset_instr", if_id_instruction, 32'h0);
    checkOutput("reset_pc4", if_id_pc_plus4, 32'h0);
    checkOutput("wrap_reset_pc", pc_w, 32'hFFFF_FFFC);
    reset_w = 1'b0;

    expectWord(32'h02114020, 32'd4);
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    checkState("fetch0", 32'd4, 1'b1, 32'd1);
    checkOutput("wrap_second_fetch", pc_w, 32'h0);
    checkOutput("wrap_pc4", if_id_pc_plus4_w, 32'h0);
    checkOutput("wrap_valid", {31'd0, if_id_valid_w}, 32'd1);

    expectWord(32'h02324822, 32'd8);
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    checkState("fetch4", 32'd8, 1'b1, 32'd2);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 16'h0, 0, 26'h0);
      checkState("stall", 32'd8, 1'b1, 32'd2);
      checkOutput("stall_instr", if_id_instruction, 32'h02324822);
      checkOutput("stall_pc4", if_id_pc_plus4, 32'd8);
    end

    expectWord(32'h8D280004, 32'd12);
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    checkState("resume", 32'd12, 1'b1, 32'd3);
    expectWord(32'hAD280008, 32'd16);
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    checkState("fetch12", 32'd16, 1'b1, 32'd4);
    expectWord(32'h11090003, 32'd20);
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    checkState("fetch16", 32'd20, 1'b1, 32'd5);

    applyStimulus(0, 0, 1, 16'd3, 0, 26'h0);
    checkState("branch", 32'd32, 1'b0, 32'd5);
    checkOutput("branch_nop", if_id_instruction, 32'h0);
    checkOutput("branch_pc4", if_id_pc_plus4, 32'h0);

    expectWord(32'h01095020, 32'd36);
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    checkState("target", 32'd36, 1'b1, 32'd6);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 1, 16'hFFFE, 0, 26'h0);
      checkState("stall_branch", 32'd36, 1'b1, 32'd6);
    end
    applyStimulus(0, 0, 1, 16'hFFFE, 0, 26'h0);
    checkState("late_branch", 32'd28, 1'b0, 32'd6);

    expectWord(32'hF00D001C, 32'd32);
    applyStimulus(0, 0, 1, 16'hFFFE, 0, 26'h0);
    checkState("branch_on_bubble", 32'd32, 1'b1, 32'd7);

    applyStimulus(0, 0, 0, 16'h0, 1, 26'd4);
    checkState("jump", 32'd16, 1'b0, 32'd7);
    expectWord(32'h11090003, 32'd20);
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    checkState("refetch16", 32'd20, 1'b1, 32'd8);

    applyStimulus(0, 0, 1, 16'd3, 1, 26'd2);
    checkState("jump_wins", 32'd8, 1'b0, 32'd8);
    expectWord(32'h8D280004, 32'd12);
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    checkState("after_jump", 32'd12, 1'b1, 32'd9);

    applyStimulus(1, 0, 0, 16'h0, 1, 26'd5);
    checkState("reset_jump", 32'd0, 1'b0, 32'd0);
    checkOutput("reset_jump_pc4", if_id_pc_plus4, 32'h0);
    applyStimulus(1, 1, 1, 16'd3, 1, 26'd5);
    checkState("reset_stall", 32'd0, 1'b0, 32'd0);

    expectWord(32'h02114020, 32'd4);
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    checkState("post_reset", 32'd4, 1'b1, 32'd1);

    stall = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
